// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use stall generator for the decode stage of the pipelined CPU.
// Latency: fwd_a/fwd_b are registered (valid while the instruction is in EX); stall is combinational.
// Backpressure: stall holds PC and IF/ID and injects a bubble into EX; flush squashes the ID instruction.
module fwd_hazard_unit #(
  parameter int N        = 5,
  parameter int ZERO_REG = 31,
  parameter int CW       = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  id_rn,
  input  logic [N-1:0]  id_rm,
  input  logic          id_rn_used,
  input  logic          id_rm_used,
  input  logic [N-1:0]  id_rd,
  input  logic          id_regwrite,
  input  logic          id_memread,
  input  logic          flush,
  output logic          stall,
  output logic [1:0]    fwd_a,
  output logic [1:0]    fwd_b,
  output logic [CW-1:0] stall_cycles
);

  localparam logic [N-1:0]  ZR      = N'(ZERO_REG);
  localparam logic [CW-1:0] CNT_MAX = '1;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EX  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;

  // Destination tracking for the instructions currently in EX and MEM.
  logic [N-1:0] ex_rd;
  logic         ex_we;
  logic         ex_ld;
  logic [N-1:0] mem_rd;
  logic         mem_we;
  logic         mem_ld;

  logic         hit_ex_a;
  logic         hit_ex_b;
  logic         hit_mem_a;
  logic         hit_mem_b;
  logic [1:0]   nxt_a;
  logic [1:0]   nxt_b;
  logic         bubble;

  // Compare the ID source registers against the EX and MEM producers; XZR never matches.
  always_comb begin
    hit_ex_a  = 1'b0;
    hit_ex_b  = 1'b0;
    hit_mem_a = 1'b0;
    hit_mem_b = 1'b0;
    hit_ex_a  = id_rn_used & ex_we  & (ex_rd  == id_rn) & (id_rn != ZR);
    hit_ex_b  = id_rm_used & ex_we  & (ex_rd  == id_rm) & (id_rm != ZR);
    hit_mem_a = id_rn_used & mem_we & (mem_rd == id_rn) & (id_rn != ZR);
    hit_mem_b = id_rm_used & mem_we & (mem_rd == id_rm) & (id_rm != ZR);
  end

  // Load-use stall and next forwarding selects; the EX producer is newest so it wins over MEM.
  always_comb begin
    stall  = 1'b0;
    nxt_a  = SEL_RF;
    nxt_b  = SEL_RF;
    bubble = 1'b0;
    stall  = ex_ld & (hit_ex_a | hit_ex_b);
    bubble = stall | flush;
    if (hit_ex_a) begin
      nxt_a = SEL_EX;
    end else if (hit_mem_a) begin
      nxt_a = SEL_MEM;
    end
    if (hit_ex_b) begin
      nxt_b = SEL_EX;
    end else if (hit_mem_b) begin
      nxt_b = SEL_MEM;
    end
  end

  // Advance the EX/MEM tracking slots, register the selects and count stall cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_rd        <= '0;
      ex_we        <= 1'b0;
      ex_ld        <= 1'b0;
      mem_rd       <= '0;
      mem_we       <= 1'b0;
      mem_ld       <= 1'b0;
      fwd_a        <= SEL_RF;
      fwd_b        <= SEL_RF;
      stall_cycles <= '0;
    end else begin
      mem_rd <= ex_rd;
      mem_we <= ex_we;
      mem_ld <= ex_ld;
      if (bubble) begin
        ex_rd <= '0;
        ex_we <= 1'b0;
        ex_ld <= 1'b0;
        fwd_a <= SEL_RF;
        fwd_b <= SEL_RF;
      end else begin
        ex_rd <= id_rd;
        ex_we <= id_regwrite;
        ex_ld <= id_memread;
        fwd_a <= nxt_a;
        fwd_b <= nxt_b;
      end
      if (stall && (stall_cycles != CNT_MAX)) begin
        stall_cycles <= stall_cycles + CW'(1);
      end
    end
  end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Sits directly downstream of the 5-bit register-number comparators in the pipelined CPU's decode stage.
- Tracks destination register number, write-enable and load flag of the instructions in EX and MEM.
- Compares them against the decode-stage source registers and produces three outputs:
  - registered forwarding selects, consumed by the EX-stage operand muxes;
  - a combinational load-use stall;
  - a saturating stall-cycle counter.

Parameters:
- N, 5, register address width.
- ZERO_REG, 31, register number that is never forwarded and never causes a stall (XZR).
- CW, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- id_rn  in  N  first source register of the instruction in ID.
- id_rm  in  N  second source register of the instruction in ID.
- id_rn_used  in  1  id_rn is actually read.
- id_rm_used  in  1  id_rm is actually read.
- id_rd  in  N  destination register of the instruction in ID.
- id_regwrite  in  1  the instruction in ID writes id_rd.
- id_memread  in  1  the instruction in ID is a load.
- flush  in  1  taken branch: squash the instruction leaving ID.
- stall  out  1  hold PC and IF/ID; inject a bubble into EX.
- fwd_a  out  2  EX operand A select: 00 regfile, 01 EX/MEM ALU result, 10 MEM/WB result.
- fwd_b  out  2  EX operand B select, same encoding as fwd_a.
- stall_cycles  out  CW  count of cycles with stall=1, saturating.

Behaviour:
- Internal state:
  - EX slot: ex_rd, ex_we, ex_ld.
  - MEM slot: mem_rd, mem_we, mem_ld.
- Match definitions:
  - match_ex(r) = ex_we & (ex_rd == r) & (r != ZERO_REG).
  - match_mem(r) = mem_we & (mem_rd == r) & (r != ZERO_REG).
- stall (combinational) = ex_ld & ((id_rn_used & match_ex(id_rn)) | (id_rm_used & match_ex(id_rm))).
- Next forwarding select for operand A (nxt_a):
  - 01 if id_rn_used & match_ex(id_rn);
  - else 10 if id_rn_used & match_mem(id_rn);
  - else 00.
  - The EX match has priority (newest value wins).
  - nxt_b: same rule using id_rm and id_rm_used.
- Rising edge, reset=1:
  - all slot fields 0;
  - fwd_a = fwd_b = 00;
  - stall_cycles = 0.
  - stall therefore reads 0 in the cycle after reset.
- Rising edge, reset=0:
  - MEM slot <= EX slot, unconditionally.
  - EX slot update:
    - if stall | flush: EX slot <= bubble (we=0, ld=0, rd=0);
    - else: EX slot <= {id_rd, id_regwrite, id_memread}.
  - fwd_a/fwd_b update:
    - if stall | flush: both <= 00;
    - else: fwd_a <= nxt_a, fwd_b <= nxt_b.
  - stall_cycles: incremented when stall=1, holds at 2^CW-1.
- Latency:
  - fwd_a/fwd_b are valid exactly one cycle after the instruction is presented in ID, i.e. while that instruction is in EX.
  - stall is same-cycle.
- Load-use sequence:
  - Cycle t: stall=1.
  - Cycle t+1: the load is in MEM and the same consumer is re-presented.
    - stall=0 and the match hits MEM, so the consumer's select is 10 (load data from MEM/WB).
  - Exactly one stall cycle per load-use pair.
- Both operands hit the same producer: both selects are identical; no extra stall.
- A producer with regwrite=0, or with rd=ZERO_REG, never forwards and never stalls.
- WB-to-ID hazards are not handled here: the register file writes on the falling edge, so a decode read sees the WB value.
- flush and stall in the same cycle: a bubble goes to EX; stall_cycles still counts the cycle.
- Reset mid-operation clears all in-flight tracking; no stale forwarding afterwards.

Test Plan:
- Reset, then an ADD X1 writer followed immediately by an ADD reading X1 as rn -> second instruction's fwd_a=01, one cycle later; fwd_b=00.
- Writer X2, one unrelated instruction, then a reader of X2 as rm -> fwd_b=10; stall=0 throughout.
- LDUR X3 followed by ADD reading X3 as rn:
  - stall=1 for exactly 1 cycle; stall_cycles goes 0 -> 1;
  - the re-presented ADD gets fwd_a=10.
- Writers to X31, and a writer to X4 with regwrite=0, each followed by readers of the same register -> fwd 00, stall 0.
- Two back-to-back writers to X5, then a reader of X5 in both rn and rm -> fwd_a=fwd_b=01 (EX priority).
- Load to X6, assert flush with the consumer in ID, and assert reset mid-sequence:
  - flushed instruction produces fwd 00 and no later stall;
  - after reset, all outputs are 0 and stall_cycles=0.
